// File: rtl/machine_jk_fsm.sv
// Overlapping "0011" sequence detector whose 3-bit state register is built from JK flip-flops.
// Optional MACHINE_JK_MEALY_EN turns F into a Mealy output raised one cycle before S4 is entered.
module machine_jk_fsm (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       x,
  output logic       F,
  output logic [2:0] S
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  logic [STATE_W-1:0] q;
  logic [STATE_W-1:0] j;
  logic [STATE_W-1:0] k;
  logic [STATE_W-1:0] q_next;

  // J/K excitation from {q,x}; unused codes 101/110/111 all fall back to S0.
  always_comb begin
    j      = '0;
    k      = '0;
    j[2]   = q[1] & q[0] & x;
    k[2]   = 1'b1;
    j[1]   = ~q[2] & q[0] & ~x;
    k[1]   = q[2] | q[0];
    j[0]   = (~q[1] & ~x) | (~q[2] & q[1] & x);
    k[0]   = q[2] | ~q[1] | x;
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) q <= '0;
    else       q <= q_next;
  end

  assign S = q;

`ifdef MACHINE_JK_MEALY_EN
  assign F = (q == S3) & x & ~RESET;
`else
  logic f_q;

  // Flag tracks "state is S4" as its own flop so F never glitches.
  always_ff @(posedge CLK) begin
    if (RESET) f_q <= 1'b0;
    else       f_q <= (q_next == S4);
  end

  assign F = f_q;
`endif

endmodule

// File: tb/tb_machine_jk_fsm.sv
// Randomized and directed bench for machine_jk_fsm against a suffix-matching reference model.
// Honours MACHINE_JK_MEALY_EN in the same way as the design.
module tb_machine_jk_fsm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       x = 1'b0;
  logic       F;
  logic [2:0] S;

  int checks = 0;
  int failures = 0;
  bit hist[$];

  machine_jk_fsm dut (
    .CLK  (CLK),
    .RESET(RESET),
    .x    (x),
    .F    (F),
    .S    (S)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", tag, act, exp, $time);
    end
  endtask

  // Longest suffix of the bits seen since reset that is a prefix of "0011".
  function automatic int match_len();
    bit pat [4];
    bit ok;
    pat = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int n = 4; n >= 1; n--) begin
      if (hist.size() >= n) begin
        ok = 1'b1;
        for (int i = 0; i < n; i++)
          if (hist[hist.size() - n + i] != pat[i]) ok = 1'b0;
        if (ok) return n;
      end
    end
    return 0;
  endfunction

  task automatic step(input bit xv, input bit rv, input string tag);
    @(negedge CLK);
    RESET = rv;
    x = ~xv;
    #2 x = xv;
    #1;
`ifdef MACHINE_JK_MEALY_EN
    check({tag, "_F_pre"}, 3'(F), 3'((match_len() == 3) && xv && !rv));
`endif
    @(posedge CLK);
    if (rv) hist.delete();
    else begin
      hist.push_back(xv);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    #1;
    check({tag, "_S"}, S, 3'(match_len()));
`ifdef MACHINE_JK_MEALY_EN
    check({tag, "_F"}, 3'(F), 3'((match_len() == 3) && xv && !rv));
`else
    check({tag, "_F"}, 3'(F), 3'(match_len() == 4));
`endif
  endtask

  task automatic seq(input string tag, input bit b0, input bit b1, input bit b2,
                     input bit b3, input bit b4);
    step(b0, 1'b0, tag);
    step(b1, 1'b0, tag);
    step(b2, 1'b0, tag);
    step(b3, 1'b0, tag);
    step(b4, 1'b0, tag);
  endtask

  task automatic illegal(input logic [2:0] v, input bit xv);
    step(1'b0, 1'b1, "ill_pre_rst");
    @(negedge CLK);
    RESET = 1'b0;
    x = xv;
    force dut.q = v;
    #1 release dut.q;
    #1;
    check("ill_forced_S", S, v);
    check("ill_forced_F", 3'(F), 3'b000);
    @(posedge CLK);
    hist.delete();
    #1;
    check("ill_recover_S", S, 3'b000);
    check("ill_recover_F", 3'(F), 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "reset");

    seq("detect", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    seq("overlap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    seq("repeat", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    step(1'b0, 1'b0, "mid_rst_a");
    step(1'b0, 1'b0, "mid_rst_b");
    step(1'b1, 1'b0, "mid_rst_c");
    step(1'b1, 1'b1, "mid_rst_s3");
    step(1'b1, 1'b0, "post_rst");

    for (int v = 5; v <= 7; v++) begin
      illegal(3'(v), 1'b0);
      illegal(3'(v), 1'b1);
    end

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/machine_jk_fsm.md
Name: machine_jk_fsm

Overview:
- Moore-type sequence detector for the overlapping serial pattern "0011" on the 1-bit input x.
- The state register is built from three JK flip-flops.
- The present state is exported on S and the detect flag on F.
- Serves as the control FSM leaf block; sampled once per CLK rising edge.

Parameters:
- None. The state width is fixed at 3 and the pattern is fixed at "0011".

Ports:
- CLK    input   1  system clock; all state updates occur on the rising edge
- RESET  input   1  synchronous, active-high reset
- x      input   1  serial data bit, sampled at each CLK rising edge
- F      output  1  detect flag: 1 while the FSM is in state S4
- S      output  3  present state vector {Q2,Q1,Q0}

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Clock port is CLK, reset port is RESET.

Behaviour:
- State register: three JK flip-flops Q2..Q0, each with a synchronous active-high reset to 0.
- JK flip-flop action: J=0,K=0 hold; J=1,K=0 set; J=0,K=1 clear; J=1,K=1 toggle.
- J/K inputs are combinational functions of {Q2,Q1,Q0,x}, derived from the excitation table below.
- No direct D-style next-state assignment.
- Reset:
  - RESET=1 at a rising edge forces S=000 and F=0, overriding all J/K values.
  - Reset takes effect mid-sequence as well; any partial match is discarded.
- State encoding and transitions (x=0 / x=1):
  - S0 000 idle: 0->S1, 1->S0
  - S1 001 seen "0": 0->S2, 1->S0
  - S2 010 seen "00": 0->S2, 1->S3
  - S3 011 seen "001": 0->S1, 1->S4
  - S4 100 seen "0011": 0->S1, 1->S0
  - Unused 101, 110, 111: go to S0 on the next edge regardless of x; F=0 in these states.
- Output F (Moore):
  - F=1 iff S==100.
  - F asserts on the edge that samples the second 1 of "0011" and lasts exactly one cycle.
- Overlap: a trailing 0 after a detection counts as the first 0 of a new pattern (S4 -x=0-> S1).
- Runs of extra zeros keep the FSM in S2, so "0000011" is detected once.
- Inputs changing between edges have no effect; only the value at the rising edge matters.
- S and F are glitch-free register outputs; F is decoded from registered state only.

Optional Feature:
- Macro: MACHINE_JK_MEALY_EN.
- Defined: F becomes a Mealy output, F = (S==011) & x, asserted combinationally in the cycle before the FSM enters S4. S behaviour is unchanged; RESET=1 forces F=0.
- Undefined (default): Moore F as specified above.

Test Plan:
- Reset: hold RESET=1 for 5 edges with x=0 -> S=000, F=0 after the first edge; also reassert RESET while in S3 -> S=000 next edge.
- Detect: after reset, x=0,0,0,1,1 on successive edges -> S=001,010,010,011,100 and F=1 for exactly the cycle after the 5th edge.
- Overlap and restart: from S4, x=0,0,0,1,0 -> S=001,010,010,011,001; F stays 0.
- Repeat detection: x=0,1,1,1,1 from S1 -> S=010? No: from S1, x=0 -> S2; then 1 -> S3; 1 -> S4 (F=1); 1 -> S0; 1 -> S0; F high for one cycle only.
- Illegal-state recovery: force state to 101, 110, 111 (each, x=0 and x=1) -> S=000 after one edge, F=0 throughout.
- MACHINE_JK_MEALY_EN defined: in S3 set x=1 -> F=1 before the edge; F=0 in S4 with x=0.
